sync_checker: RTL and testbench
===============================

# sync_checker

Self-checking monitor for the two-flop `sync` synchronizer: the hardware counterpart of the vector-driven stimulus side. It samples the bit driven into the synchronizer (`d`) and the bit it produces (`q`), and compares each output against the input delayed by the synchronizer latency. It accumulates a saturating error count, captures the first failing vector index, and reports pass/fail through a start/busy/done handshake. It sits beside the synchronizer in loopback benches and FPGA self-test builds.

## Interface
- `LATENCY`, default 2: synchronizer latency in cycles; legal range 1..8.
- `NUM_VEC`, default 16: number of vectors compared per run; legal range ≥ 2.
- `ERR_W`, default 8: width of the error counter.
- `IDX_W`, default `$clog2(NUM_VEC)`: width of the vector-index outputs.

Ports (name, direction, width, meaning):
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `start` in 1: run request; accepted only in IDLE or DONE.
- `d` in 1: bit applied to the synchronizer input in this cycle.
- `q` in 1: synchronizer output in this cycle.
- `busy` out 1: high during FILL and CHECK.
- `done` out 1: one-cycle pulse at run completion.
- `pass` out 1: high when the last completed run had zero errors; held.
- `err_count` out ERR_W: mismatches in the current or last run; saturating.
- `first_err_valid` out 1: at least one mismatch has been captured.
- `first_err_idx` out IDX_W: vector index of the first mismatch.
- `vec_idx` out IDX_W: index of the vector compared this cycle; valid in CHECK.

## Operation
- States: IDLE, FILL, CHECK, DONE.
- **IDLE**
  - `start`=1 → FILL.
  - Clears the history register, `err_count`, `first_err_*` and `pass`.
- **FILL**
  - Lasts exactly LATENCY cycles.
  - Each cycle shifts `d` into the LATENCY-deep history; no comparison.
  - → CHECK after cycle LATENCY-1.
- **CHECK**
  - Lasts exactly NUM_VEC cycles.
  - Each cycle compares `q` against `d` sampled LATENCY cycles earlier (the history tail) and keeps shifting `d` in.
  - `vec_idx` counts 0..NUM_VEC-1.
  - On a mismatch:
    - `err_count` increments, saturating at 2^ERR_W-1 with no wrap.
    - If `first_err_valid`=0, set it and load `first_err_idx` with `vec_idx`.
  - → DONE after `vec_idx`=NUM_VEC-1.
- **DONE**
  - `done`=1 for the entry cycle only.
  - `pass` = (`err_count`==0), held, as are `err_count` and `first_err_*`.
  - `start`=1 → FILL, with the same clearing as IDLE. Results stay visible until that restart.
- `start` during FILL or CHECK is ignored; the run is neither restarted nor lengthened.
- Run cycle k (k=0 is the first FILL cycle) compares for k ≥ LATENCY only: `q`ₖ vs `d`ₖ₋LATENCY.
- The stimulus must keep driving `d` during the final LATENCY cycles of CHECK. Those bits are shifted in but never compared.

## Timing
- Reset (async assert, any state):
  - State → IDLE.
  - `busy`=`done`=`pass`=0, `err_count`=0, `first_err_valid`=0, `first_err_idx`=0, `vec_idx`=0, history=0.
  - Reset mid-run discards the run; no `done` pulse is produced.
- Deassertion is taken synchronously to `clk`. The first `start` is accepted on the first rising edge with `rst_n`=1.
- `start` sampled high at edge E:
  - `busy` rises after E and stays high for LATENCY+NUM_VEC cycles.
  - `done` and the valid `pass` appear in the next cycle; `busy` is 0 in that cycle.
- Start-to-done latency: LATENCY+NUM_VEC+1 cycles.
- The mismatch increment is visible the cycle after the compare. `first_err_idx` updates in the same cycle.
- Back-to-back runs: `start` in the DONE cycle gives zero idle cycles between runs.
- Counter widths: the FILL counter is `$clog2(LATENCY+1)` bits. `vec_idx` holds NUM_VEC-1 without overflow.

## Test plan
- **Clean run.** Defaults; model `q` as `d` delayed by 2 cycles; 16 random vectors.
  - Expect `done` 19 cycles after `start`, `pass`=1, `err_count`=0, `first_err_valid`=0.
- **Single fault.** Invert `q` only at `vec_idx`=5.
  - Expect `err_count`=1, `first_err_idx`=5, `pass`=0.
- **Wrong latency.** Delay `q` by 3 instead of 2; `d`=0101…
  - Expect `err_count`=16, `first_err_idx`=0.
- **Saturation.** ERR_W=4, NUM_VEC=32, `q`=~delayed `d`.
  - Expect `err_count`=15 (no wrap) and `pass`=0.
- **Ignored start.** Pulse `start` during CHECK at `vec_idx`=7.
  - Expect `done` still exactly 19 cycles after the original `start`, with results unchanged.
- **Reset and restart.**
  - Assert `rst_n`=0 at `vec_idx`=9 after one error. Expect all outputs 0 immediately and no `done` pulse.
  - Then a clean run gives `pass`=1.
  - Then `start` in the DONE cycle runs back-to-back and clears `err_count` on restart.

Source files
------------

// File: rtl/sync_checker.sv
// Compares synchronizer output q against input d delayed LATENCY cycles over NUM_VEC vectors.
// Start-to-done latency is LATENCY+NUM_VEC+1 cycles; there is no backpressure, and start is ignored while busy.
module sync_checker #(
  parameter int LATENCY = 2,
  parameter int NUM_VEC = 16,
  parameter int ERR_W   = 8,
  parameter int IDX_W   = $clog2(NUM_VEC)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             d,
  input  logic             q,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             first_err_valid,
  output logic [IDX_W-1:0] first_err_idx,
  output logic [IDX_W-1:0] vec_idx
);
  localparam int                FILL_W    = $clog2(LATENCY + 1);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(LATENCY - 1);
  localparam logic [IDX_W-1:0]  VEC_LAST  = IDX_W'(NUM_VEC - 1);
  localparam logic [ERR_W-1:0]  ERR_MAX   = '1;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_CHECK, S_DONE} state_t;

  state_t              state, state_nxt;
  logic [FILL_W-1:0]   fill_cnt;
  logic [LATENCY-1:0]  hist;
  logic                launch, mismatch, fill_last, check_last;

  assign fill_last  = (fill_cnt == FILL_LAST);
  assign check_last = (vec_idx == VEC_LAST);
  assign busy       = (state == S_FILL) || (state == S_CHECK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    mismatch  = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          launch    = 1'b1;
          state_nxt = S_FILL;
        end
      end
      S_FILL: begin
        if (fill_last) state_nxt = S_CHECK;
      end
      S_CHECK: begin
        // History tail holds d from exactly LATENCY cycles ago.
        mismatch = (q != hist[LATENCY-1]);
        if (check_last) state_nxt = S_DONE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done            <= 1'b0;
      pass            <= 1'b0;
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_idx   <= '0;
      vec_idx         <= '0;
      fill_cnt        <= '0;
      hist            <= '0;
    end else begin
      done <= (state == S_CHECK) && check_last;
      if (launch || state == S_IDLE) begin
        pass            <= 1'b0;
        err_count       <= '0;
        first_err_valid <= 1'b0;
        first_err_idx   <= '0;
        vec_idx         <= '0;
        fill_cnt        <= '0;
        hist            <= '0;
      end else if (busy) begin
        hist[0] <= d;
        for (int i = 1; i < LATENCY; i++) hist[i] <= hist[i-1];
        if (state == S_FILL) begin
          fill_cnt <= fill_cnt + FILL_W'(1);
        end else begin
          if (!check_last) vec_idx <= vec_idx + IDX_W'(1);
          if (mismatch) begin
            if (err_count != ERR_MAX) err_count <= err_count + ERR_W'(1);
            if (!first_err_valid) begin
              first_err_valid <= 1'b1;
              first_err_idx   <= vec_idx;
            end
          end
          // Last compare of the run still counts toward pass.
          if (check_last) pass <= (err_count == '0) && !mismatch;
        end
      end
    end
  end
endmodule

// File: tb/tb_sync_checker.sv
// Directed bench for sync_checker: table of runs plus reset, saturation and back-to-back sequences.
module tb_sync_checker;
  localparam int L = 2;
  localparam int N = 16;

  logic       clk = 1'b0;
  logic       rst_n, start, d, q, start_s, q_s;
  logic       busy, done, pass, fv;
  logic [7:0] err;
  logic [3:0] fidx, vidx;
  logic       busy_s, done_s, pass_s, fv_s;
  logic [3:0] err_s;
  logic [4:0] fidx_s, vidx_s;
  logic [7:0] dh = '0;
  int checks = 0;
  int errors = 0;

  sync_checker dut (
    .clk(clk), .rst_n(rst_n), .start(start), .d(d), .q(q),
    .busy(busy), .done(done), .pass(pass), .err_count(err),
    .first_err_valid(fv), .first_err_idx(fidx), .vec_idx(vidx)
  );

  sync_checker #(.LATENCY(2), .NUM_VEC(32), .ERR_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start_s), .d(d), .q(q_s),
    .busy(busy_s), .done(done_s), .pass(pass_s), .err_count(err_s),
    .first_err_valid(fv_s), .first_err_idx(fidx_s), .vec_idx(vidx_s)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    pat;      // 0 random, 1 alternating 0101
    int    delay;    // model synchronizer delay
    int    flip_k;   // run cycle whose q is inverted, -1 none
    bit    inv;      // invert q on every cycle
    int    glitch_k; // extra start pulse cycle, -1 none
    int    e_err, e_fv, e_fidx, e_pass;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string run, input string what, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s/%s: got %0d, expected %0d", run, what, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    dh = {dh[6:0], d};
  endtask

  function automatic logic pat_bit(input int p, input int k);
    if (p == 1) return (k & 1) != 0;
    return $urandom_range(0, 1) == 1;
  endfunction

  task automatic run_rec(input vec_t r, input int k0, input bit b2b);
    int done_k = -1, done_n = 0, busy_n = 0, vec_bad = 0;
    int c_err = -1, c_fv = -1, c_fidx = -1, c_pass = -1;
    int kend = b2b ? L + N : L + N + 1;
    for (int k = k0; k <= kend; k++) begin
      d = pat_bit(r.pat, k);
      q = dh[r.delay-1] ^ (k == r.flip_k) ^ r.inv;
      start = (k == -1) || (k == r.glitch_k) || (b2b && k == L + N);
      if (k >= 0) begin
        if (done) begin
          done_n++;
          if (done_k < 0) done_k = k;
        end
        if (busy) busy_n++;
        if (k >= L && k < L + N && int'(vidx) != k - L) vec_bad++;
        if (k == L + N) begin
          c_err = int'(err); c_fv = int'(fv); c_fidx = int'(fidx); c_pass = int'(pass);
        end
      end
      tick();
    end
    start = 1'b0;
    chk(r.name, "done_cycle", done_k, L + N);
    chk(r.name, "done_pulses", done_n, 1);
    chk(r.name, "busy_cycles", busy_n, L + N);
    chk(r.name, "vec_idx_seq_bad", vec_bad, 0);
    chk(r.name, "err_count", c_err, r.e_err);
    chk(r.name, "first_err_valid", c_fv, r.e_fv);
    chk(r.name, "first_err_idx", c_fidx, r.e_fidx);
    chk(r.name, "pass", c_pass, r.e_pass);
  endtask

  initial begin
    int dn, bn, sdone_k, s_err, s_fv, s_fidx, s_pass;
    tbl[0] = '{"clean",      0, 2, -1, 1'b0, -1,  0, 0,  0, 1};
    tbl[1] = '{"fault_v5",   0, 2,  7, 1'b0, -1,  1, 1,  5, 0};
    tbl[2] = '{"latency3",   1, 3, -1, 1'b0, -1, 16, 1,  0, 0};
    tbl[3] = '{"ign_start",  0, 2, -1, 1'b0,  9,  0, 0,  0, 1};
    tbl[4] = '{"fault_fill", 0, 2,  1, 1'b0, -1,  0, 0,  0, 1};
    tbl[5] = '{"fault_v0",   0, 2,  2, 1'b0, -1,  1, 1,  0, 0};
    tbl[6] = '{"fault_v15",  0, 2, 17, 1'b0, -1,  1, 1, 15, 0};
    tbl[7] = '{"invert_all", 0, 2, -1, 1'b1, -1, 16, 1,  0, 0};

    rst_n = 1'b0; start = 1'b0; start_s = 1'b0; d = 1'b0; q = 1'b0; q_s = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset", "busy", int'(busy), 0);
    chk("reset", "done", int'(done), 0);
    chk("reset", "pass", int'(pass), 0);
    chk("reset", "err_count", int'(err), 0);
    chk("reset", "first_err_valid", int'(fv), 0);
    chk("reset", "vec_idx", int'(vidx), 0);
    chk("reset", "sat_err_count", int'(err_s), 0);
    rst_n = 1'b1;
    tick();
    tick();

    foreach (tbl[i]) run_rec(tbl[i], -3, 1'b0);

    // Saturation on the 4-bit counter instance with q inverted every cycle.
    sdone_k = -1; s_err = -1; s_fv = -1; s_fidx = -1; s_pass = -1;
    for (int k = -1; k <= 35; k++) begin
      d = pat_bit(0, k);
      q_s = ~dh[1];
      start_s = (k == -1);
      if (k >= 0 && done_s && sdone_k < 0) sdone_k = k;
      if (k == 34) begin
        s_err = int'(err_s); s_fv = int'(fv_s); s_fidx = int'(fidx_s); s_pass = int'(pass_s);
      end
      tick();
    end
    start_s = 1'b0;
    chk("saturate", "done_cycle", sdone_k, 34);
    chk("saturate", "err_count", s_err, 15);
    chk("saturate", "first_err_valid", s_fv, 1);
    chk("saturate", "first_err_idx", s_fidx, 0);
    chk("saturate", "pass", s_pass, 0);

    // Mid-run reset after one error at vec_idx 3.
    for (int k = -3; k <= 10; k++) begin
      d = pat_bit(0, k);
      q = dh[1] ^ (k == 5);
      start = (k == -1);
      tick();
    end
    chk("midrun", "vec_idx", int'(vidx), 9);
    chk("midrun", "err_count", int'(err), 1);
    chk("midrun", "first_err_idx", int'(fidx), 3);
    rst_n = 1'b0;
    #1;
    chk("rst_async", "busy", int'(busy), 0);
    chk("rst_async", "done", int'(done), 0);
    chk("rst_async", "pass", int'(pass), 0);
    chk("rst_async", "err_count", int'(err), 0);
    chk("rst_async", "first_err_valid", int'(fv), 0);
    chk("rst_async", "first_err_idx", int'(fidx), 0);
    chk("rst_async", "vec_idx", int'(vidx), 0);
    dn = 0; bn = 0;
    for (int i = 0; i < 25; i++) begin
      if (i == 2) rst_n = 1'b1;
      q = dh[1];
      if (done) dn++;
      if (busy) bn++;
      tick();
    end
    chk("post_reset", "done_pulses", dn, 0);
    chk("post_reset", "busy_cycles", bn, 0);

    run_rec(tbl[0], -3, 1'b0);
    run_rec(tbl[1], -3, 1'b1);
    chk("b2b", "busy_after_done", int'(busy), 1);
    chk("b2b", "err_cleared", int'(err), 0);
    chk("b2b", "first_err_valid_cleared", int'(fv), 0);
    chk("b2b", "pass_cleared", int'(pass), 0);
    run_rec(tbl[0], 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
